// File: rtl/ctrl_unit.sv
// ctrl_unit: instruction sequencer for data_path.
//
// The sequencer takes one instruction at a time from a synchronous instruction
// memory addressed by the datapath PC. For each instruction it:
//   - fetches and decodes it,
//   - pulses the datapath,
//   - waits for the ALU to finish,
//   - writes the result back,
//   - then increments or loads the PC.
// After start it keeps running until it reaches a HALT, an illegal opcode or an
// ALU timeout.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   start        begins execution; sampled only in IDLE
//   instr[15:0]  imem read data, valid one cycle after the PC changes
//   alu_done     ALU completion (data_path en_out)
//   dp_en        one-cycle enable pulse to data_path
//   en_pc_pulse  one-cycle PC update strobe
//   pc_ctrl[1:0] 00 hold, 01 load offset_addr, 10 increment
//   offset_addr  jump target
//   offset       immediate operand
//   rd, rs       register selects
//   reg_en[3:0]  one-hot writeback enable for rd (one-cycle pulse)
//   alu_func     000 PASS_B, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR
//   alu_in_sel   1 = immediate drives alu_b
//   busy         high in every state except IDLE and HALTED
//   halted       high in HALTED
//   err          sticky error flag (illegal opcode or ALU timeout)
module ctrl_unit #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] instr,
    input  logic        alu_done,
    output logic        dp_en,
    output logic        en_pc_pulse,
    output logic [1:0]  pc_ctrl,
    output logic [7:0]  offset_addr,
    output logic [7:0]  offset,
    output logic [1:0]  rd,
    output logic [1:0]  rs,
    output logic [3:0]  reg_en,
    output logic [2:0]  alu_func,
    output logic        alu_in_sel,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT_ALU,
        S_WB,
        S_PC_UPD,
        S_HALTED
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_MOV  = 4'h1,
        OP_MVI  = 4'h2,
        OP_ADD  = 4'h3,
        OP_ADDI = 4'h4,
        OP_SUB  = 4'h5,
        OP_SUBI = 4'h6,
        OP_AND  = 4'h7,
        OP_OR   = 4'h8,
        OP_XOR  = 4'h9,
        OP_JMP  = 4'hA,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        F_PASS_B = 3'b000,
        F_ADD    = 3'b001,
        F_SUB    = 3'b010,
        F_AND    = 3'b011,
        F_OR     = 3'b100,
        F_XOR    = 3'b101
    } func_e;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_LOAD = 2'b01;
    localparam logic [1:0] PC_INC  = 2'b10;

    // Last counter value in WAIT_ALU before giving up: WAIT_ALU lasts at most TIMEOUT cycles.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    function automatic func_e func_of(input op_e op);
        func_e f;
        f = F_PASS_B;
        case (op)
            OP_ADD, OP_ADDI: f = F_ADD;
            OP_SUB, OP_SUBI: f = F_SUB;
            OP_AND:          f = F_AND;
            OP_OR:           f = F_OR;
            OP_XOR:          f = F_XOR;
            default:         f = F_PASS_B;
        endcase
        return f;
    endfunction

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  rd_q;
    logic [1:0]  rs_q;
    logic [7:0]  imm_q;
    func_e       alu_func_q;
    logic        alu_in_sel_q;
    logic        dp_en_q;
    logic        en_pc_q;
    logic [1:0]  pc_ctrl_q;
    logic [3:0]  reg_en_q;
    logic        busy_q;
    logic        halted_q;
    logic        err_q;

    op_e op_w;
    assign op_w = op_e'(instr[15:12]);

    // Outputs are registered. Each strobe is set on the edge that enters its
    // state and is cleared by default on every other edge. That makes every
    // strobe last exactly one cycle. An asynchronous reset clears them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rd_q         <= '0;
            rs_q         <= '0;
            imm_q        <= '0;
            alu_func_q   <= F_PASS_B;
            alu_in_sel_q <= 1'b0;
            dp_en_q      <= 1'b0;
            en_pc_q      <= 1'b0;
            pc_ctrl_q    <= PC_HOLD;
            reg_en_q     <= '0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            dp_en_q   <= 1'b0;
            en_pc_q   <= 1'b0;
            pc_ctrl_q <= PC_HOLD;
            reg_en_q  <= '0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                    end
                end

                S_FETCH: state_q <= S_DECODE;

                S_DECODE: begin
                    rd_q         <= instr[11:10];
                    rs_q         <= instr[9:8];
                    imm_q        <= instr[7:0];
                    alu_func_q   <= F_PASS_B;
                    alu_in_sel_q <= 1'b0;
                    case (op_w)
                        OP_NOP: begin
                            en_pc_q   <= 1'b1;
                            pc_ctrl_q <= PC_INC;
                            state_q   <= S_PC_UPD;
                        end
                        OP_JMP: begin
                            en_pc_q   <= 1'b1;
                            pc_ctrl_q <= PC_LOAD;
                            state_q   <= S_PC_UPD;
                        end
                        OP_HALT: begin
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end
                        OP_MOV, OP_MVI, OP_ADD, OP_ADDI, OP_SUB,
                        OP_SUBI, OP_AND, OP_OR, OP_XOR: begin
                            alu_func_q   <= func_of(op_w);
                            alu_in_sel_q <= (op_w == OP_MVI) || (op_w == OP_ADDI) ||
                                            (op_w == OP_SUBI);
                            dp_en_q      <= 1'b1;
                            state_q      <= S_EXEC;
                        end
                        default: begin
                            err_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end
                    endcase
                end

                S_EXEC: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_ALU;
                end

                // If done arrives in the last allowed cycle, it still wins over the timeout.
                S_WAIT_ALU: begin
                    if (alu_done) begin
                        reg_en_q <= 4'b0001 << rd_q;
                        state_q  <= S_WB;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q    <= cnt_q + 4'd1;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= S_HALTED;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                S_WB: begin
                    en_pc_q   <= 1'b1;
                    pc_ctrl_q <= PC_INC;
                    state_q   <= S_PC_UPD;
                end

                S_PC_UPD: state_q <= S_FETCH;

                S_HALTED: state_q <= S_HALTED;

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The immediate goes to the ALU, so it is zero-filled if the datapath is narrower than 8 bits.
    if (DWIDTH >= 8) begin : g_imm_full
        assign offset = imm_q;
    end else begin : g_imm_narrow
        assign offset = {{(8 - DWIDTH){1'b0}}, imm_q[DWIDTH-1:0]};
    end

    assign offset_addr = imm_q;
    assign rd          = rd_q;
    assign rs          = rs_q;
    assign alu_func    = alu_func_q;
    assign alu_in_sel  = alu_in_sel_q;
    assign dp_en       = dp_en_q;
    assign en_pc_pulse = en_pc_q;
    assign pc_ctrl     = pc_ctrl_q;
    assign reg_en      = reg_en_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Testbench for ctrl_unit.
// - It contains a model of the synchronous instruction memory and the PC, and
//   an ALU responder that raises alu_done a fixed number of cycles after dp_en.
// - For each instruction, the expected strobe events are pushed into a queue,
//   stamped with the cycle in which they should appear.
// - A negedge monitor pops one entry for every observed strobe cycle and
//   compares the two.
module tb_ctrl_unit;

    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] instr;
    logic        alu_done;
    logic        dp_en;
    logic        en_pc_pulse;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic [7:0]  offset;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [3:0]  reg_en;
    logic [2:0]  alu_func;
    logic        alu_in_sel;
    logic        busy;
    logic        halted;
    logic        err;

    ctrl_unit #(.DWIDTH(16), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instr       (instr),
        .alu_done    (alu_done),
        .dp_en       (dp_en),
        .en_pc_pulse (en_pc_pulse),
        .pc_ctrl     (pc_ctrl),
        .offset_addr (offset_addr),
        .offset      (offset),
        .rd          (rd),
        .rs          (rs),
        .reg_en      (reg_en),
        .alu_func    (alu_func),
        .alu_in_sel  (alu_in_sel),
        .busy        (busy),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic        dp_en;
        logic        en_pc;
        logic [1:0]  pc_ctrl;
        logic [3:0]  reg_en;
        logic        halt_rise;
        logic        err;
        logic [1:0]  rd;
        logic [1:0]  rs;
        logic [7:0]  imm;
        logic [2:0]  func;
        logic        sel;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned done_delay = 0;
    logic [15:0] mem [256];
    logic [7:0]  pc;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic ev_t mk_ev(input int unsigned c, input logic d, input logic p,
                                  input logic [1:0] pcc, input logic [3:0] re,
                                  input logic h, input logic e, input logic [1:0] r_d,
                                  input logic [1:0] r_s, input logic [7:0] im,
                                  input logic [2:0] f, input logic s);
        ev_t v;
        v.cyc = c; v.dp_en = d; v.en_pc = p; v.pc_ctrl = pcc; v.reg_en = re;
        v.halt_rise = h; v.err = e; v.rd = r_d; v.rs = r_s; v.imm = im;
        v.func = f; v.sel = s;
        return v;
    endfunction

    function automatic logic [2:0] exp_func(input logic [3:0] op);
        case (op)
            4'h3, 4'h4: return 3'b001;
            4'h5, 4'h6: return 3'b010;
            4'h7:       return 3'b011;
            4'h8:       return 3'b100;
            4'h9:       return 3'b101;
            default:    return 3'b000;
        endcase
    endfunction

    // Push the events expected for one instruction whose FETCH cycle is t.
    // n is the number of WAIT cycles before alu_done arrives; n = 0 means it never arrives.
    task automatic expect_instr(input logic [15:0] ir, input int unsigned n,
                                inout int unsigned t);
        logic [3:0] op;
        logic [1:0] erd;
        logic [1:0] ers;
        logic [7:0] eimm;
        logic       esel;
        op = ir[15:12]; erd = ir[11:10]; ers = ir[9:8]; eimm = ir[7:0];
        esel = (op == 4'h2) || (op == 4'h4) || (op == 4'h6);
        if (op == 4'h0) begin
            exp_q.push_back(mk_ev(t + 2, 0, 1, 2'b10, 4'h0, 0, 0, 2'b00, 2'b00, 8'h00, 3'b000, 0));
            t += 3;
        end else if (op == 4'hA) begin
            exp_q.push_back(mk_ev(t + 2, 0, 1, 2'b01, 4'h0, 0, 0, 2'b00, 2'b00, eimm, 3'b000, 0));
            t += 3;
        end else if (op == 4'hF) begin
            exp_q.push_back(mk_ev(t + 2, 0, 0, 2'b00, 4'h0, 1, 0, 2'b00, 2'b00, 8'h00, 3'b000, 0));
        end else if (op >= 4'hB) begin
            exp_q.push_back(mk_ev(t + 2, 0, 0, 2'b00, 4'h0, 1, 1, 2'b00, 2'b00, 8'h00, 3'b000, 0));
        end else begin
            exp_q.push_back(mk_ev(t + 2, 1, 0, 2'b00, 4'h0, 0, 0, erd, ers, eimm, exp_func(op), esel));
            if (n == 0) begin
                exp_q.push_back(mk_ev(t + 3 + TIMEOUT, 0, 0, 2'b00, 4'h0, 1, 1,
                                      2'b00, 2'b00, 8'h00, 3'b000, 0));
            end else begin
                exp_q.push_back(mk_ev(t + 3 + n, 0, 0, 2'b00, 4'b0001 << erd, 0, 0,
                                      2'b00, 2'b00, 8'h00, 3'b000, 0));
                exp_q.push_back(mk_ev(t + 4 + n, 0, 1, 2'b10, 4'h0, 0, 0,
                                      2'b00, 2'b00, 8'h00, 3'b000, 0));
                t += 5 + n;
            end
        end
    endtask

    // Instruction memory and PC model: the PC updates on en_pc_pulse, and the read data follows one cycle later.
    initial begin
        logic [7:0] a;
        pc = '0;
        instr = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                pc = '0;
                instr = '0;
            end else begin
                a = pc;
                if (en_pc_pulse && pc_ctrl == 2'b10) pc = pc + 8'd1;
                else if (en_pc_pulse && pc_ctrl == 2'b01) pc = offset_addr;
                #1 instr = mem[a];
            end
        end
    end

    // ALU responder: alu_done is high during WAIT cycle number done_delay.
    initial begin
        alu_done = 1'b0;
        forever begin
            @(negedge clk);
            if (dp_en && done_delay > 0) begin
                repeat (done_delay) @(negedge clk);
                alu_done = 1'b1;
                @(negedge clk);
                alu_done = 1'b0;
            end
        end
    end

    // Monitor and scoreboard.
    initial begin
        logic halted_prev;
        ev_t  obs;
        ev_t  e;
        halted_prev = 1'b0;
        forever begin
            @(negedge clk);
            checks++;
            assert (en_pc_pulse || pc_ctrl === 2'b00) else begin
                errors++;
                $error("FAIL pc_ctrl_idle: got %b expected 00", pc_ctrl);
            end
            if (dp_en || en_pc_pulse || reg_en != 4'h0 || (halted && !halted_prev)) begin
                obs = mk_ev(cyc, dp_en, en_pc_pulse, pc_ctrl, reg_en, halted && !halted_prev,
                            err, 2'b00, 2'b00, 8'h00, 3'b000, 1'b0);
                if (dp_en) begin
                    obs.rd = rd; obs.rs = rs; obs.imm = offset;
                    obs.func = alu_func; obs.sel = alu_in_sel;
                end else if (en_pc_pulse && pc_ctrl == 2'b01) begin
                    obs.imm = offset_addr;
                end
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_event: got %h expected no event", obs);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (obs === e) else begin
                        errors++;
                        $error("FAIL event: got %h expected %h", obs, e);
                    end
                end
            end
            halted_prev = halted;
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_idle(input string tag);
        logic [34:0] o;
        o = {dp_en, en_pc_pulse, pc_ctrl, offset_addr, offset, rd, rs, reg_en,
             alu_func, alu_in_sel, busy, halted, err};
        checks++;
        assert (o === 35'd0) else begin
            errors++;
            $error("FAIL %s: got %h expected 0", tag, o);
        end
    endtask

    task automatic check_flags(input string tag, input logic [2:0] want);
        checks++;
        assert ({busy, halted, err} === want) else begin
            errors++;
            $error("FAIL %s: got busy/halted/err %b expected %b", tag, {busy, halted, err}, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Raise start before an edge; t becomes the FETCH cycle.
    task automatic begin_run(output int unsigned t, input logic hold);
        start = 1'b1;
        @(negedge clk);
        t = cyc;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input logic [2:0] flags);
        int k;
        k = 0;
        while (halted !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        assert (halted === 1'b1) else begin
            errors++;
            $error("FAIL %s_halt: got %b expected 1", tag, halted);
        end
        // Keep start high through the halt: a halted unit must ignore it.
        start = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        start = 1'b0;
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL %s_pending: got %0d events left expected 0", tag, exp_q.size());
        end
        check_flags({tag, "_flags"}, flags);
    endtask

    initial begin
        int unsigned t;
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        repeat (2) @(negedge clk);
        check_idle("reset_outputs");
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("idle_after_reset");

        // Program: MVI, ADD, JMP, NOP, AND, ADDI, HALT. Start stays high while busy.
        mem[8'h00] = 16'h2405;
        mem[8'h01] = 16'h3E00;
        mem[8'h02] = 16'hA020;
        mem[8'h20] = 16'h0000;
        mem[8'h21] = 16'h7100;
        mem[8'h22] = 16'h46AA;
        mem[8'h23] = 16'hF000;
        done_delay = 2;
        begin_run(t, 1'b1);
        expect_instr(16'h2405, 2, t);
        expect_instr(16'h3E00, 2, t);
        expect_instr(16'hA020, 2, t);
        expect_instr(16'h0000, 2, t);
        expect_instr(16'h7100, 2, t);
        expect_instr(16'h46AA, 2, t);
        expect_instr(16'hF000, 2, t);
        wait_done("program", 200, 3'b010);

        // ALU never completes: timeout after TIMEOUT wait cycles, no writeback.
        do_reset();
        check_idle("reset_before_timeout");
        mem[8'h00] = 16'h5B33;
        done_delay = 0;
        begin_run(t, 1'b0);
        expect_instr(16'h5B33, 0, t);
        wait_done("timeout", 100, 3'b011);

        // Done arriving in the last allowed wait cycle still writes back.
        do_reset();
        mem[8'h00] = 16'h9100;
        mem[8'h01] = 16'hF000;
        done_delay = TIMEOUT;
        begin_run(t, 1'b0);
        expect_instr(16'h9100, TIMEOUT, t);
        expect_instr(16'hF000, TIMEOUT, t);
        wait_done("done_at_limit", 100, 3'b010);

        // Illegal opcode.
        do_reset();
        mem[8'h00] = 16'hC000;
        begin_run(t, 1'b0);
        expect_instr(16'hC000, 0, t);
        wait_done("illegal", 50, 3'b011);

        // Reset while waiting on the ALU; the late alu_done must not cause a writeback.
        do_reset();
        mem[8'h00] = 16'h2405;
        mem[8'h01] = 16'hF000;
        done_delay = 5;
        begin_run(t, 1'b0);
        expect_instr(16'h2405, 5, t);
        exp_q.delete(exp_q.size() - 1);
        exp_q.delete(exp_q.size() - 1);
        repeat (3) @(negedge clk);
        check_flags("in_wait", 3'b100);
        #1 rst = 1'b1;
        #1 check_idle("async_reset_drop");
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check_idle("ignore_late_done");
        done_delay = 2;
        begin_run(t, 1'b0);
        expect_instr(16'h2405, 2, t);
        expect_instr(16'hF000, 2, t);
        wait_done("restart", 100, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
